// File: rtl/seq_gen.sv
// Serial pattern generator: streams a latched word MSB-first, repeated rep+1 times,
// and counts overlapping "101" occurrences in the emitted burst.
module seq_gen #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] data,
   input  logic [4:0]   len,
   input  logic [3:0]   rep,
   output logic         x,
   output logic         x_vld,
   output logic         busy,
   output logic         done,
   output logic [4:0]   hits
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [4:0] LEN_MAX = 5'(W);

   state_t       state_q, state_d;
   logic [W-1:0] pat_q, pat_d;
   logic [4:0]   len_q, len_d;
   logic [3:0]   rep_left_q, rep_left_d;
   logic [4:0]   idx_q, idx_d;
   logic [1:0]   hist_q, hist_d;
   logic [4:0]   hits_d;
   logic         x_d, x_vld_d, busy_d, done_d;

   logic [4:0]   len_eff;
   logic [W-1:0] shifted;

   // State, pattern bookkeeping and every output are registered together.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         pat_q      <= '0;
         len_q      <= '0;
         rep_left_q <= '0;
         idx_q      <= '0;
         hist_q     <= '0;
         hits       <= '0;
         x          <= 1'b0;
         x_vld      <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         state_q    <= state_d;
         pat_q      <= pat_d;
         len_q      <= len_d;
         rep_left_q <= rep_left_d;
         idx_q      <= idx_d;
         hist_q     <= hist_d;
         hits       <= hits_d;
         x          <= x_d;
         x_vld      <= x_vld_d;
         busy       <= busy_d;
         done       <= done_d;
      end
   end

   // Next-state and next-output logic; x/x_vld/busy/done default low so they only
   // assert for the state that is about to be entered.
   always_comb begin
      state_d    = state_q;
      pat_d      = pat_q;
      len_d      = len_q;
      rep_left_d = rep_left_q;
      idx_d      = idx_q;
      hist_d     = hist_q;
      hits_d     = hits;
      x_d        = 1'b0;
      x_vld_d    = 1'b0;
      busy_d     = 1'b0;
      done_d     = 1'b0;
      len_eff    = (len == 5'd0 || len > LEN_MAX) ? LEN_MAX : len;
      shifted    = '0;

      // The bit currently on x is scored here, so a hit shows up one cycle later.
      if (x_vld) begin
         hist_d = {hist_q[0], x};
         if (hist_q == 2'b10 && x && hits != 5'd31) begin
            hits_d = hits + 5'd1;
         end
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               pat_d      = data;
               len_d      = len_eff;
               rep_left_d = rep;
               idx_d      = len_eff - 5'd1;
               shifted    = data >> (len_eff - 5'd1);
               x_d        = shifted[0];
               x_vld_d    = 1'b1;
               busy_d     = 1'b1;
               hits_d     = '0;
               hist_d     = '0;
               state_d    = SHIFT;
            end
         end
         SHIFT: begin
            if (idx_q != 5'd0) begin
               idx_d   = idx_q - 5'd1;
               shifted = pat_q >> (idx_q - 5'd1);
               x_d     = shifted[0];
               x_vld_d = 1'b1;
               busy_d  = 1'b1;
            end else if (rep_left_q != 4'd0) begin
               rep_left_d = rep_left_q - 4'd1;
               idx_d      = len_q - 5'd1;
               shifted    = pat_q >> (len_q - 5'd1);
               x_d        = shifted[0];
               x_vld_d    = 1'b1;
               busy_d     = 1'b1;
            end else begin
               done_d  = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_seq_gen.sv
// Directed bench for seq_gen: table of bursts with hand-computed streams and hit
// counts, plus hand-written sequences for reset, ignored starts and back-to-back starts.
module tb_seq_gen;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] data;
   logic [4:0] len;
   logic [3:0] rep;
   logic       x, x_vld, busy, done;
   logic [4:0] hits;

   int compared = 0;
   int mismatched = 0;

   seq_gen #(.W(8)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .data  (data),
      .len   (len),
      .rep   (rep),
      .x     (x),
      .x_vld (x_vld),
      .busy  (busy),
      .done  (done),
      .hits  (hits)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic [7:0] data;
      logic [4:0] len;
      logic [3:0] rep;
      logic       disturb;
      int         cycles;
      int         hits;
      logic [15:0] head;
   } vec_t;

   vec_t vecs[9];

   task automatic applyStimulus(input logic [7:0] d, input logic [4:0] l,
                                input logic [3:0] r, input logic s);
      data  = d;
      len   = l;
      rep   = r;
      start = s;
   endtask

   task automatic checkOutput(input string name, input int actual, input int expected);
      compared++;
      if (actual != expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   // Start a burst before an edge, then follow the stream one negedge at a time.
   task automatic runBurst(input vec_t v);
      int n;
      int guard;
      logic [15:0] h;
      applyStimulus(v.data, v.len, v.rep, 1'b1);
      @(negedge clk);
      start = 1'b0;
      checkOutput({v.name, " first x_vld"}, int'(x_vld), 1);
      n = 0;
      guard = 0;
      while (x_vld && guard < 300) begin
         if (n < 16) begin
            h = v.head << n;
            checkOutput({v.name, " x bit"}, int'(x), int'(h[15]));
         end
         checkOutput({v.name, " busy"}, int'(busy), 1);
         if (v.disturb && n == 2) applyStimulus(8'h00, 5'd3, 4'd5, 1'b1);
         if (v.disturb && n == 3) start = 1'b0;
         n++;
         guard++;
         @(negedge clk);
      end
      if (guard >= 300) checkOutput({v.name, " stream timeout"}, 1, 0);
      checkOutput({v.name, " bit count"}, n, v.cycles);
      checkOutput({v.name, " done"}, int'(done), 1);
      checkOutput({v.name, " busy in done"}, int'(busy), 0);
      checkOutput({v.name, " x in done"}, int'(x), 0);
      checkOutput({v.name, " hits"}, int'(hits), v.hits);
      @(negedge clk);
      checkOutput({v.name, " done width"}, int'(done), 0);
      checkOutput({v.name, " hits held"}, int'(hits), v.hits);
   endtask

   initial begin
      int n;
      int guard;
      vecs[0] = '{"p101",     8'h05, 5'd3,  4'd0,  1'b0, 3,   1,  16'hA000};
      vecs[1] = '{"pA5",      8'hA5, 5'd8,  4'd0,  1'b0, 8,   2,  16'hA500};
      vecs[2] = '{"p101x3",   8'h05, 5'd3,  4'd2,  1'b0, 9,   3,  16'hB680};
      vecs[3] = '{"ones128",  8'hFF, 5'd0,  4'd15, 1'b0, 128, 0,  16'hFFFF};
      vecs[4] = '{"alt128",   8'hAA, 5'd0,  4'd15, 1'b0, 128, 31, 16'hAAAA};
      vecs[5] = '{"lenbig",   8'h81, 5'd20, 4'd0,  1'b0, 8,   0,  16'h8100};
      vecs[6] = '{"len1",     8'h01, 5'd1,  4'd2,  1'b0, 3,   0,  16'hE000};
      vecs[7] = '{"p10101x2", 8'h15, 5'd5,  4'd1,  1'b0, 10,  4,  16'hAD40};
      vecs[8] = '{"busystart",8'hA5, 5'd8,  4'd0,  1'b1, 8,   2,  16'hA500};

      rst = 1'b1;
      applyStimulus(8'h00, 5'd0, 4'd0, 1'b0);
      repeat (3) @(negedge clk);
      checkOutput("reset x", int'(x), 0);
      checkOutput("reset x_vld", int'(x_vld), 0);
      checkOutput("reset busy", int'(busy), 0);
      checkOutput("reset done", int'(done), 0);
      checkOutput("reset hits", int'(hits), 0);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 9; i++) begin
         runBurst(vecs[i]);
         @(negedge clk);
      end

      // Reset in the 4th SHIFT cycle aborts the burst without a done pulse.
      applyStimulus(8'hA5, 5'd8, 4'd0, 1'b1);
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("abort hits before rst", int'(hits), 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checkOutput("abort x_vld", int'(x_vld), 0);
      checkOutput("abort busy", int'(busy), 0);
      checkOutput("abort hits", int'(hits), 0);
      checkOutput("abort done", int'(done), 0);
      @(negedge clk);
      checkOutput("abort no done later", int'(done), 0);
      checkOutput("abort stays idle", int'(x_vld), 0);

      // Reset wins over start on the same edge.
      rst = 1'b1;
      applyStimulus(8'hA5, 5'd8, 4'd0, 1'b1);
      @(negedge clk);
      checkOutput("rst+start x_vld", int'(x_vld), 0);
      checkOutput("rst+start busy", int'(busy), 0);
      rst = 1'b0;
      start = 1'b0;
      @(negedge clk);
      checkOutput("rst+start stays idle", int'(x_vld), 0);

      // Start held through DONE is ignored there and taken in the following IDLE cycle.
      applyStimulus(8'h05, 5'd3, 4'd0, 1'b1);
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("b2b done", int'(done), 1);
      applyStimulus(8'hA5, 5'd8, 4'd0, 1'b1);
      @(negedge clk);
      checkOutput("b2b start ignored in done", int'(x_vld), 0);
      checkOutput("b2b hits held", int'(hits), 1);
      @(negedge clk);
      start = 1'b0;
      checkOutput("b2b accepted x_vld", int'(x_vld), 1);
      checkOutput("b2b first bit", int'(x), 1);
      n = 0;
      guard = 0;
      while (x_vld && guard < 50) begin
         n++;
         guard++;
         @(negedge clk);
      end
      checkOutput("b2b bit count", n, 8);
      checkOutput("b2b done", int'(done), 1);
      checkOutput("b2b hits", int'(hits), 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
